// File: rtl/mchan_hp_filter_if.sv
// rtl/mchan_hp_filter_if.sv - sample/channel-number stream with valid/read handshake
interface mchan_hp_filter_if #(
  parameter int DATA_W = 16,
  parameter int NUM_W  = 3
) ();
  logic [DATA_W-1:0] sample;
  logic [NUM_W-1:0]  num;
  logic              valid;
  logic              read;

  modport master (output sample, num, valid, input read);
  modport slave  (input sample, num, valid, output read);
endinterface

// File: rtl/mchan_hp_filter.sv
// rtl/mchan_hp_filter.sv - time-multiplexed multi-channel DC-blocking high-pass filter
module mchan_hp_filter #(
  parameter int CHANNELS     = 8,
  parameter int CHANNELS_PW2 = 3,
  parameter int DATA_W       = 16,
  parameter int COEFF_W      = 16,
  parameter int FRAC_W       = 8
) (
  input  logic               clk,
  input  logic               reset,
  mchan_hp_filter_if.slave   chan_in,
  mchan_hp_filter_if.master  chan_out,
  input  logic [COEFF_W-1:0] coeff,
  input  logic               bypass,
  input  logic               offset_bin,
  input  logic               clear_req,
  output logic               busy
);

  localparam int ACC_W  = DATA_W + FRAC_W;
  // Signed difference (ACC_W+1) times zero-extended coeff never exceeds this width
  localparam int PROD_W = ACC_W + 1 + COEFF_W;

  localparam logic [CHANNELS_PW2-1:0] LAST_CH = CHANNELS_PW2'(CHANNELS - 1);
  localparam logic [DATA_W-1:0]       SAT_MAX = {1'b0, {(DATA_W-1){1'b1}}};
  localparam logic [DATA_W-1:0]       SAT_MIN = {1'b1, {(DATA_W-1){1'b0}}};

  typedef enum logic {ST_CLEAR, ST_RUN} state_t;

  state_t                  state;
  logic [CHANNELS_PW2-1:0] sweep;

  // Per-channel DC estimate, DATA_W integer bits over FRAC_W fraction bits
  logic signed [ACC_W-1:0] acc_mem [CHANNELS];

  logic                    in_read;
  logic                    in_fire;
  logic                    in_range;
  logic                    passthru;
  logic                    acc_we;
  logic signed [DATA_W-1:0] x;
  logic signed [ACC_W-1:0] acc_rd;
  logic signed [ACC_W-1:0] acc_shr;
  logic        [DATA_W:0]  diff_y;
  logic        [DATA_W-1:0] y_sat;
  logic        [DATA_W-1:0] y_core;
  logic        [DATA_W-1:0] y_out;
  logic        [ACC_W:0]   acc_diff;
  logic signed [PROD_W-1:0] prod;
  logic        [ACC_W-1:0] acc_step;
  logic signed [ACC_W-1:0] acc_next;
  logic                    unused_bits;

  logic [DATA_W-1:0]       out_sample_q;
  logic [CHANNELS_PW2-1:0] out_num_q;
  logic                    out_valid_q;

  // Accept only while running and the output slot is empty or draining this edge
  assign in_read  = (state == ST_RUN) && (!out_valid_q || chan_out.read);
  assign in_fire  = chan_in.valid && in_read;
  assign chan_in.read = in_read;

  // Offset-binary samples become two's complement by flipping the MSB
  assign x = offset_bin ? {~chan_in.sample[DATA_W-1], chan_in.sample[DATA_W-2:0]}
                        : chan_in.sample;

  assign in_range = (32'(chan_in.num) < CHANNELS);
  assign acc_rd   = in_range ? acc_mem[chan_in.num] : '0;

  // Unknown channels, bypass and a zero coefficient all forward x untouched
  assign passthru = bypass || !in_range || (coeff == '0);
  assign acc_we   = in_fire && !passthru;

  // y = x - floor(acc / 2^FRAC_W), one guard bit then clamp
  assign acc_shr = acc_rd >>> FRAC_W;
  assign diff_y  = {x[DATA_W-1], x} - {acc_shr[DATA_W-1], acc_shr[DATA_W-1:0]};
  assign y_sat   = (diff_y[DATA_W] == diff_y[DATA_W-1]) ? diff_y[DATA_W-1:0]
                 : (diff_y[DATA_W] ? SAT_MIN : SAT_MAX);
  assign y_core  = passthru ? x : y_sat;
  assign y_out   = offset_bin ? {~y_core[DATA_W-1], y_core[DATA_W-2:0]} : y_core;

  // acc += floor(((x << FRAC_W) - acc) * coeff / 2^COEFF_W)
  assign acc_diff = {x[DATA_W-1], x, {FRAC_W{1'b0}}} - {acc_rd[ACC_W-1], acc_rd};
  assign prod     = PROD_W'($signed(acc_diff)) * $signed({{(PROD_W-COEFF_W){1'b0}}, coeff});
  // Bit slice of the product is the arithmetic right shift by COEFF_W
  assign acc_step = prod[COEFF_W +: ACC_W];
  assign acc_next = acc_rd + acc_step;

  // The estimate stays between old acc and x<<FRAC_W, so the dropped bits are pure sign
  assign unused_bits = ^{prod[PROD_W-1], prod[COEFF_W-1:0], acc_shr[ACC_W-1:DATA_W]};

  // Control FSM: CLEAR sweeps one accumulator per cycle, RUN filters
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_CLEAR;
      sweep <= '0;
      busy  <= 1'b1;
    end else begin
      case (state)
        ST_CLEAR: begin
          if (clear_req) begin
            sweep <= '0;
          end else if (sweep == LAST_CH) begin
            state <= ST_RUN;
            sweep <= '0;
            busy  <= 1'b0;
          end else begin
            sweep <= sweep + 1'b1;
          end
        end
        ST_RUN: begin
          if (clear_req) begin
            state <= ST_CLEAR;
            sweep <= '0;
            busy  <= 1'b1;
          end
        end
        default: begin
          state <= ST_CLEAR;
          sweep <= '0;
          busy  <= 1'b1;
        end
      endcase
    end
  end

  // Accumulator store: sweep zeroing in CLEAR, filter update on accepted samples in RUN
  always_ff @(posedge clk) begin
    if (state == ST_CLEAR) begin
      acc_mem[sweep] <= '0;
    end else if (acc_we) begin
      acc_mem[chan_in.num] <= acc_next;
    end
  end

  // Output slot: load on accept (replacing a draining entry), empty once taken
  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid_q  <= 1'b0;
      out_sample_q <= '0;
      out_num_q    <= '0;
    end else if (in_fire) begin
      out_valid_q  <= 1'b1;
      out_sample_q <= y_out;
      out_num_q    <= chan_in.num;
    end else if (chan_out.read) begin
      out_valid_q  <= 1'b0;
    end
  end

  assign chan_out.sample = out_sample_q;
  assign chan_out.num    = out_num_q;
  assign chan_out.valid  = out_valid_q;

endmodule
